// File: rtl/bra_upd_ctl.sv
// bra_upd_ctl: in-flight branch record FIFO that turns resolved outcomes into BHT/PHT update strobes.
module bra_upd_ctl #(
  parameter int ADDR_W = 6,
  parameter int HIST_W = 10,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pre_valid,
  input  logic [ADDR_W-1:0]        pre_addr,
  input  logic [HIST_W-1:0]        pre_hist,
  input  logic                     pre_taken,
  output logic                     pre_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     res_ready,
  output logic                     bht_up_en,
  output logic [ADDR_W-1:0]        bht_addr,
  output logic                     bht_wr_data,
  output logic                     pht_up_en,
  output logic [HIST_W-1:0]        pht_idx,
  output logic                     pht_inc,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              mis_cnt
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [HIST_W-1:0] hist_mem [DEPTH];
  logic [DEPTH-1:0]  taken_mem;
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]       count_q, count_d;
  logic              push, pop, mis;
  assign count     = count_q;
  assign pre_ready = count_q != (PW+1)'(DEPTH);
  assign res_ready = count_q != '0;
  // a mispredict flushes every younger record, including one pushed this cycle
  always_comb begin
    push    = pre_valid && pre_ready;
    pop     = res_valid && res_ready;
    mis     = pop && (res_taken != taken_mem[rd_q]);
    wr_d    = mis ? '0 : wr_q + PW'(push);
    rd_d    = mis ? '0 : rd_q + PW'(pop);
    count_d = mis ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_q]  <= pre_addr;
      hist_mem[wr_q]  <= pre_hist;
      taken_mem[wr_q] <= pre_taken;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      bht_up_en   <= 1'b0;
      bht_addr    <= '0;
      bht_wr_data <= 1'b0;
      pht_up_en   <= 1'b0;
      pht_idx     <= '0;
      pht_inc     <= 1'b0;
      mispredict  <= 1'b0;
      mis_cnt     <= '0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      bht_up_en   <= pop;
      bht_addr    <= pop ? addr_mem[rd_q] : '0;
      bht_wr_data <= pop & res_taken;
      pht_up_en   <= pop;
      pht_idx     <= pop ? hist_mem[rd_q] : '0;
      pht_inc     <= pop & res_taken;
      mispredict  <= mis;
      if (mis && mis_cnt != 16'hFFFF) mis_cnt <= mis_cnt + 16'd1;
    end
  end
endmodule
